// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the multicycle MIPS controller
package mc_pkg;
    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_RTYPEEX = 4'd6;
    localparam logic [3:0] S_RTYPEWB = 4'd7;
    localparam logic [3:0] S_BEQEX   = 4'd8;
    localparam logic [3:0] S_BNEEX   = 4'd9;
    localparam logic [3:0] S_IEX     = 4'd10;
    localparam logic [3:0] S_IWB     = 4'd11;
    localparam logic [3:0] S_JEX     = 4'd12;
    localparam logic [3:0] S_JALEX   = 4'd13;
    localparam logic [3:0] S_TRAP    = 4'd14;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [2:0] {
        AOP_ADD, AOP_SUB, AOP_FUNCT, AOP_AND, AOP_OR, AOP_SLT
    } aluop_t;
endpackage

// File: rtl/mc_aludec.sv
// mc_aludec: aluop/funct to alucontrol; o_valid flags a supported R-type funct
module mc_aludec
    import mc_pkg::*;
(
    input  aluop_t     i_aluop,
    input  logic [5:0] i_funct,
    output logic [2:0] o_alucontrol,
    output logic       o_valid
);
    logic [2:0] w_fctl;

    always_comb begin
        w_fctl  = ALU_ADD;
        o_valid = 1'b1;
        case (i_funct)
            F_ADD:   w_fctl = ALU_ADD;
            F_SUB:   w_fctl = ALU_SUB;
            F_AND:   w_fctl = ALU_AND;
            F_OR:    w_fctl = ALU_OR;
            F_SLT:   w_fctl = ALU_SLT;
            default: o_valid = 1'b0;
        endcase
        o_alucontrol = ALU_ADD;
        case (i_aluop)
            AOP_SUB:   o_alucontrol = ALU_SUB;
            AOP_FUNCT: o_alucontrol = w_fctl;
            AOP_AND:   o_alucontrol = ALU_AND;
            AOP_OR:    o_alucontrol = ALU_OR;
            AOP_SLT:   o_alucontrol = ALU_SLT;
            default:   o_alucontrol = ALU_ADD;
        endcase
    end
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle MIPS controller with memready handshake, timeout and trap
// Define MC_CTRL_PERF_EN to add the instret/stallcnt performance counters.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
`ifdef MC_CTRL_PERF_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       memready,
    output logic       memread,
    output logic       memwrite,
    output logic       pcen,
    output logic       irwrite,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       immext,
    output logic       iord,
    output logic [1:0] memtoreg,
    output logic [1:0] regdst,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       illegal,
    output logic       buserr
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] instret,
    output logic [CNT_W-1:0] stallcnt
`endif
);
    localparam int TW = $clog2(MEM_TIMEOUT + 2);

    logic [3:0]    r_state, w_next;
    logic [TW-1:0] r_cnt;
    logic          r_illegal, r_buserr;
    logic          w_memread, w_memwrite, w_pcwrite, w_irwrite, w_regwrite;
    logic          w_branch, w_bne, w_fvalid, w_wait, w_to;
    aluop_t        w_aluop, w_iaop;

    mc_aludec u_aludec (
        .i_aluop      (w_aluop),
        .i_funct      (funct),
        .o_alucontrol (alucontrol),
        .o_valid      (w_fvalid)
    );

    assign w_wait = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    // Timeout fires on the MEM_TIMEOUT-th wait cycle; memready in that cycle still wins.
    assign w_to   = (MEM_TIMEOUT != 0) && !memready && (r_cnt == TW'(MEM_TIMEOUT - 1));
    assign w_iaop = (op == OP_ANDI) ? AOP_AND : (op == OP_ORI) ? AOP_OR :
                    (op == OP_SLTI) ? AOP_SLT : AOP_ADD;

    always_comb begin
        w_memread  = 1'b0;
        w_memwrite = 1'b0;
        w_pcwrite  = 1'b0;
        w_irwrite  = 1'b0;
        w_regwrite = 1'b0;
        w_branch   = 1'b0;
        w_bne      = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        immext     = 1'b0;
        iord       = 1'b0;
        memtoreg   = 2'b00;
        regdst     = 2'b00;
        pcsrc      = 2'b00;
        w_aluop    = AOP_ADD;
        w_next     = r_state;
        case (r_state)
            S_FETCH: begin
                w_memread = 1'b1;
                alusrcb   = 2'b01;
                w_irwrite = memready;
                w_pcwrite = memready;
                w_next    = memready ? S_DECODE : w_to ? S_TRAP : S_FETCH;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW:                      w_next = S_MEMADR;
                    OP_RTYPE:                          w_next = w_fvalid ? S_RTYPEEX : S_TRAP;
                    OP_BEQ:                            w_next = S_BEQEX;
                    OP_BNE:                            w_next = S_BNEEX;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: w_next = S_IEX;
                    OP_J:                              w_next = S_JEX;
                    OP_JAL:                            w_next = S_JALEX;
                    default:                           w_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                w_next  = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                w_memread = 1'b1;
                iord      = 1'b1;
                w_next    = memready ? S_MEMWB : w_to ? S_TRAP : S_MEMRD;
            end
            S_MEMWB: begin
                w_regwrite = 1'b1;
                memtoreg   = 2'b01;
                w_next     = S_FETCH;
            end
            S_MEMWR: begin
                w_memwrite = 1'b1;
                iord       = 1'b1;
                w_next     = memready ? S_FETCH : w_to ? S_TRAP : S_MEMWR;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                w_aluop = AOP_FUNCT;
                w_next  = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                w_regwrite = 1'b1;
                regdst     = 2'b01;
                w_next     = S_FETCH;
            end
            S_BEQEX, S_BNEEX: begin
                alusrca  = 1'b1;
                w_aluop  = AOP_SUB;
                pcsrc    = 2'b01;
                w_branch = 1'b1;
                w_bne    = (r_state == S_BNEEX);
                w_next   = S_FETCH;
            end
            S_IEX, S_IWB: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                w_aluop    = w_iaop;
                immext     = (op == OP_ANDI) || (op == OP_ORI);
                w_regwrite = (r_state == S_IWB);
                w_next     = (r_state == S_IEX) ? S_IWB : S_FETCH;
            end
            S_JEX, S_JALEX: begin
                pcsrc      = 2'b10;
                w_pcwrite  = 1'b1;
                w_regwrite = (r_state == S_JALEX);
                regdst     = (r_state == S_JALEX) ? 2'b10 : 2'b00;
                memtoreg   = (r_state == S_JALEX) ? 2'b10 : 2'b00;
                w_next     = S_FETCH;
            end
            default: w_next = r_state;
        endcase
    end

    // Strobes are gated by the raw reset so nothing fires while it is held.
    assign memread  = reset & w_memread;
    assign memwrite = reset & w_memwrite;
    assign irwrite  = reset & w_irwrite;
    assign regwrite = reset & w_regwrite;
    assign pcen     = reset & (w_pcwrite | (w_branch & (zero ^ w_bne)));
    assign illegal  = r_illegal;
    assign buserr   = r_buserr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_FETCH;
            r_cnt     <= '0;
            r_illegal <= 1'b0;
            r_buserr  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= (w_next != r_state) ? '0 : (w_wait && !memready) ? r_cnt + 1'b1 : r_cnt;
            r_illegal <= r_illegal | ((r_state == S_DECODE) && (w_next == S_TRAP));
            r_buserr  <= r_buserr | (w_wait && (w_next == S_TRAP));
        end
    end

`ifdef MC_CTRL_PERF_EN
    logic [CNT_W-1:0] r_instret, r_stallcnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instret  <= '0;
            r_stallcnt <= '0;
        end else begin
            if ((w_next == S_FETCH) && (r_state != S_FETCH))
                r_instret <= r_instret + 1'b1;
            if (w_wait && !memready)
                r_stallcnt <= r_stallcnt + 1'b1;
        end
    end

    assign instret  = r_instret;
    assign stallcnt = r_stallcnt;
`endif
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed-vector bench for mc_ctrl (MEM_TIMEOUT=4)
module tb_mc_ctrl;
    import mc_pkg::*;

    logic       clk = 1'b0;
    logic       reset, zero, memready;
    logic [5:0] op, funct;
    logic       memread, memwrite, pcen, irwrite, regwrite, alusrca, immext, iord;
    logic [1:0] alusrcb, memtoreg, regdst, pcsrc;
    logic [2:0] alucontrol;
    logic       illegal, buserr;
    logic [4:0] st;
    int         n_vec = 0;
    int         n_err = 0;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] instret, stallcnt;
`endif

    always #5 clk = ~clk;

    mc_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .memready   (memready),
        .memread    (memread),
        .memwrite   (memwrite),
        .pcen       (pcen),
        .irwrite    (irwrite),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .immext     (immext),
        .iord       (iord),
        .memtoreg   (memtoreg),
        .regdst     (regdst),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .illegal    (illegal),
        .buserr     (buserr)
`ifdef MC_CTRL_PERF_EN
        ,
        .instret    (instret),
        .stallcnt   (stallcnt)
`endif
    );

    // Strobe vector order: memread, memwrite, pcen, irwrite, regwrite
    assign st = {memread, memwrite, pcen, irwrite, regwrite};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [4:0] exp);
        @(negedge clk);
        check(tag, 32'(st), 32'(exp));
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic front(input string tag);
        cyc({tag, "_fetch"}, 5'b10110);
        check({tag, "_fetch_srcb"}, 32'(alusrcb), 'b01);
        nxt;
        cyc({tag, "_dec"}, 5'b00000);
        check({tag, "_dec_srcb"}, 32'(alusrcb), 'b11);
        nxt;
    endtask

    task automatic rst_pulse(input string tag);
        reset = 1'b0;
        cyc(tag, 5'b00000);
        check({tag, "_ill"}, 32'(illegal), 0);
        check({tag, "_berr"}, 32'(buserr), 0);
        nxt;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; memready = 1'b1; zero = 1'b0; op = OP_LW; funct = 6'd0;
        rst_pulse("rst");

        front("lw");
        cyc("lw_adr", 5'b00000);
        check("lw_adr_srca", 32'(alusrca), 1);
        check("lw_adr_srcb", 32'(alusrcb), 'b10);
        nxt;
        cyc("lw_rd", 5'b10000);
        check("lw_rd_iord", 32'(iord), 1);
        nxt;
        cyc("lw_wb", 5'b00001);
        check("lw_wb_m2r", 32'(memtoreg), 'b01);
        check("lw_wb_rdst", 32'(regdst), 'b00);
        nxt;

        op = OP_SW;
        front("sw");
        cyc("sw_adr", 5'b00000);
        nxt;
        memready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc("sw_wait", 5'b01000);
            nxt;
        end
        memready = 1'b1;
        cyc("sw_wr", 5'b01000);
        check("sw_wr_iord", 32'(iord), 1);
        nxt;

        op = OP_BNE; zero = 1'b0;
        front("bne_t");
`ifdef MC_CTRL_PERF_EN
        check("perf_instret", instret, 2);
        check("perf_stall", stallcnt, 3);
`endif
        cyc("bne_t_ex", 5'b00100);
        check("bne_t_pcsrc", 32'(pcsrc), 'b01);
        check("bne_t_alu", 32'(alucontrol), 'b110);
        nxt;
        zero = 1'b1;
        front("bne_nt");
        cyc("bne_nt_ex", 5'b00000);
        nxt;
        op = OP_BEQ;
        front("beq_t");
        cyc("beq_t_ex", 5'b00100);
        nxt;
        zero = 1'b0;
        front("beq_nt");
        cyc("beq_nt_ex", 5'b00000);
        nxt;

        op = OP_JAL;
        front("jal");
        cyc("jal_ex", 5'b00101);
        check("jal_rdst", 32'(regdst), 'b10);
        check("jal_m2r", 32'(memtoreg), 'b10);
        check("jal_pcsrc", 32'(pcsrc), 'b10);
        nxt;

        op = OP_ORI;
        front("ori");
        cyc("ori_ex", 5'b00000);
        check("ori_ex_alu", 32'(alucontrol), 'b001);
        check("ori_ex_ext", 32'(immext), 1);
        nxt;
        cyc("ori_wb", 5'b00001);
        check("ori_wb_alu", 32'(alucontrol), 'b001);
        check("ori_wb_srcb", 32'(alusrcb), 'b10);
        check("ori_wb_m2r", 32'(memtoreg), 'b00);
        nxt;

        op = OP_SLTI;
        front("slti");
        cyc("slti_ex", 5'b00000);
        check("slti_alu", 32'(alucontrol), 'b111);
        check("slti_ext", 32'(immext), 0);
        nxt;
        nxt;

        op = OP_RTYPE; funct = F_SUB;
        front("rsub");
        cyc("rsub_ex", 5'b00000);
        check("rsub_alu", 32'(alucontrol), 'b110);
        check("rsub_srcb", 32'(alusrcb), 'b00);
        nxt;
        cyc("rsub_wb", 5'b00001);
        check("rsub_rdst", 32'(regdst), 'b01);
        nxt;

        op = OP_J;
        front("j");
        cyc("j_ex", 5'b00100);
        check("j_pcsrc", 32'(pcsrc), 'b10);
        nxt;

        op = OP_RTYPE; funct = 6'b000111;
        front("rill");
        cyc("rill_trap", 5'b00000);
        check("rill_ill", 32'(illegal), 1);
        check("rill_berr", 32'(buserr), 0);
        nxt;
        for (int i = 0; i < 3; i++) begin
            cyc("rill_hold", 5'b00000);
            nxt;
        end
        rst_pulse("rst2");

        op = 6'b111111;
        front("iop");
        cyc("iop_trap", 5'b00000);
        check("iop_ill", 32'(illegal), 1);
        nxt;
        rst_pulse("rst3");

        op = OP_LW; memready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc("to_wait", 5'b10000);
            nxt;
        end
        cyc("to_trap", 5'b00000);
        check("to_berr", 32'(buserr), 1);
        check("to_ill", 32'(illegal), 0);
        memready = 1'b1;
        nxt;
        cyc("to_hold", 5'b00000);
`ifdef MC_CTRL_PERF_EN
        check("to_stall_frozen", stallcnt, 4);
`endif
        nxt;
        memready = 1'b0;
        rst_pulse("rst4");

        for (int i = 0; i < 3; i++) begin
            cyc("nto_wait", 5'b10000);
            nxt;
        end
        memready = 1'b1;
        cyc("nto_fetch", 5'b10110);
        nxt;
        cyc("nto_dec", 5'b00000);
        check("nto_berr", 32'(buserr), 0);
`ifdef MC_CTRL_PERF_EN
        check("nto_instret", instret, 0);
        check("nto_stall", stallcnt, 3);
`endif
        nxt;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Second-generation multicycle MIPS controller: main-decoder FSM plus ALU decoder, driving the existing multicycle datapath.
- Extends the first-generation controller with:
  - a variable-latency memory handshake (memready) and a parametrised timeout,
  - ANDI/ORI/SLTI/BNE/JAL support,
  - an illegal-instruction/bus-error trap.
- Sits between the instruction register fields (op, funct), the ALU zero flag, the memory system and the datapath control inputs.

Parameters:
- MEM_TIMEOUT, 16, maximum cycles waiting for memready before bus-error trap; 0 disables the timeout.
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset)
- op  input  6  instr[31:26]
- funct  input  6  instr[5:0]
- zero  input  1  ALU zero flag
- memready  input  1  memory completes the current read/write this cycle
- memread  output  1  memory read request
- memwrite  output  1  memory write request
- pcen  output  1  PC register enable
- irwrite  output  1  instruction register enable
- regwrite  output  1  register file write enable
- alusrca  output  1  0=PC, 1=A
- alusrcb  output  2  00=B, 01=4, 10=imm, 11=imm<<2
- immext  output  1  0=sign-extend, 1=zero-extend
- iord  output  1  0=PC address, 1=ALUOut address
- memtoreg  output  2  00=ALUOut, 01=Data, 10=PC
- regdst  output  2  00=rt, 01=rd, 10=r31
- pcsrc  output  2  00=ALUResult, 01=ALUOut, 10=jump target
- alucontrol  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- illegal  output  1  sticky: unsupported op/funct trapped
- buserr  output  1  sticky: memory timeout trapped

Behaviour:
- Reset (reset=0, async):
  - state=FETCH; illegal=0, buserr=0, timeout counter=0.
  - All strobes (memread, memwrite, pcen, irwrite, regwrite) are forced 0 while reset=0.
  - First fetch request is issued in the first cycle after release.
- Control style:
  - Moore decode from state.
  - irwrite and pcwrite in FETCH, and state advance out of wait states, are additionally qualified by memready.
  - pcen = pcwrite | (branch & (zero ^ bne)).
  - Signals not listed for a state are 0; alucontrol is don't-care where not listed.
- States and outputs:
  - FETCH: memread=1, iord=0, alusrcb=01, add.
    - memready=1: irwrite=1, pcwrite=1, go to DECODE.
    - memready=0: stay.
  - DECODE: alusrcb=11, add. Next state by op:
    - LW/SW → MEMADR
    - RTYPE → RTYPEEX; any funct outside {add, sub, and, or, slt} → TRAP with illegal=1
    - BEQ → BEQEX; BNE → BNEEX
    - ADDI/ANDI/ORI/SLTI → IEX
    - J → JEX; JAL → JALEX
    - any other op → TRAP with illegal=1
  - MEMADR: alusrca=1, alusrcb=10, add. LW → MEMRD, SW → MEMWR.
  - MEMRD: memread=1, iord=1. Wait for memready, then → MEMWB.
  - MEMWB: regwrite=1, regdst=00, memtoreg=01 → FETCH.
  - MEMWR: memwrite=1, iord=1. Wait for memready, then → FETCH.
  - RTYPEEX: alusrca=1, alusrcb=00, alucontrol from funct → RTYPEWB.
  - RTYPEWB: regwrite=1, regdst=01 → FETCH.
  - BEQEX / BNEEX: alusrca=1, sub, pcsrc=01, branch=1; BNEEX also sets bne=1 → FETCH.
  - IEX: alusrca=1, alusrcb=10, then → IWB. Per opcode:
    - ADDI: add, immext=0
    - ANDI: and, immext=1
    - ORI: or, immext=1
    - SLTI: slt, immext=0
  - IWB: IEX mux settings held, regwrite=1, regdst=00, memtoreg=00 → FETCH.
  - JEX: pcsrc=10, pcwrite=1 → FETCH.
  - JALEX: pcsrc=10, pcwrite=1, regwrite=1, regdst=10, memtoreg=10 (PC already holds PC+4) → FETCH.
  - TRAP: all strobes 0; exit only by reset.
- Handshake:
  - Requests are held high until memready; memready outside FETCH/MEMRD/MEMWR is ignored.
  - A request and its memready may coincide in the same cycle (zero wait states).
- Timeout:
  - Counter clears on entry to FETCH/MEMRD/MEMWR and increments each cycle memready=0.
  - If the count reaches MEM_TIMEOUT with memready still 0 → TRAP, buserr=1.
  - memready=1 in that same cycle wins: normal advance, no trap.
- illegal and buserr are mutually exclusive; the first trap cause is kept.

Optional Feature:
- Macro MC_CTRL_PERF_EN.
- Defined: adds outputs instret[CNT_W-1:0] and stallcnt[CNT_W-1:0].
  - instret increments on every transition into FETCH from a completing state.
  - stallcnt increments on each wait cycle (request high, memready=0).
  - Both wrap modulo 2^CNT_W, clear on reset and freeze in TRAP.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package mc_pkg holds:
  - state encoding (4-bit),
  - opcode constants (LW, SW, RTYPE, BEQ, BNE, ADDI, ANDI, ORI, SLTI, J, JAL),
  - funct constants,
  - alucontrol constants,
  - internal 3-bit aluop codes (add, sub, funct, and, or, slt).
- One sub-module, mc_aludec: combinational aluop+funct → alucontrol, with a valid flag that DECODE uses for the R-type illegal check.

Test Plan:
- Release reset, memready=1 constant, LW (op=100011) → cycle 1 FETCH irwrite=pcen=1, memory read on cycle 4, MEMWB regwrite=1 memtoreg=01; back to FETCH after 5 cycles.
- SW with memready low for 3 cycles in MEMWR → memwrite held 4 cycles, regwrite never 1, then FETCH; stallcnt=+3 with MC_CTRL_PERF_EN.
- BNE with zero=0 → pcen=1, pcsrc=01. Same with zero=1 → pcen=0. BEQ behaves inversely.
- JAL → pcen=1, regwrite=1, regdst=10, memtoreg=10 in one cycle; ORI → alucontrol=001, immext=1.
- op=111111, or RTYPE with funct=000111 → TRAP, illegal=1, no further memread until reset=0 pulse.
- MEM_TIMEOUT=4, memready held 0 in FETCH → after 4 wait cycles TRAP, buserr=1. Repeat with memready=1 on the 4th cycle → no trap.
